// File: rtl/ycbcr422_group_demux_pkg.sv
// Shared types for the 4:2:2 group demux: byte orders, beat index and the
// beat-to-field lookup that decodes each byte order.
package ycbcr_pkg;

  typedef enum logic [1:0] {
    ORD_YUYV = 2'd0,
    ORD_UYVY = 2'd1,
    ORD_YVYU = 2'd2,
    ORD_VYUY = 2'd3
  } order_e;

  typedef logic [1:0] beat_t;

  typedef enum logic [1:0] {
    FLD_Y0 = 2'd0,
    FLD_Y1 = 2'd1,
    FLD_CB = 2'd2,
    FLD_CR = 2'd3
  } field_e;

  localparam int    NUM_FIELDS = 4;
  localparam beat_t LAST_BEAT  = 2'd3;

  // Which pair field the byte at a given beat of a group carries.
  function automatic field_e beat_field(input order_e ord, input beat_t beat);
    field_e map [4];
    case (ord)
      ORD_UYVY: map = '{FLD_CB, FLD_Y0, FLD_CR, FLD_Y1};
      ORD_YVYU: map = '{FLD_Y0, FLD_CR, FLD_Y1, FLD_CB};
      ORD_VYUY: map = '{FLD_CR, FLD_Y0, FLD_CB, FLD_Y1};
      default:  map = '{FLD_Y0, FLD_CB, FLD_Y1, FLD_CR};
    endcase
    return map[beat];
  endfunction

endpackage

// File: rtl/ycbcr422_group_demux_if.sv
// Camera byte stream in, aligned pixel-pair stream out (ready/valid).
interface ycbcr422_group_demux_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] pixel_in;
  logic              pixel_valid;
  logic              frame_start;
  logic              line_end;

  logic [DATA_W-1:0] out_y0;
  logic [DATA_W-1:0] out_y1;
  logic [DATA_W-1:0] out_cb;
  logic [DATA_W-1:0] out_cr;
  logic              out_sof;
  logic              out_eol;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  pixel_in, pixel_valid, frame_start, line_end, out_ready,
    output out_y0, out_y1, out_cb, out_cr, out_sof, out_eol, out_valid
  );

  modport master (
    output pixel_in, pixel_valid, frame_start, line_end, out_ready,
    input  out_y0, out_y1, out_cb, out_cr, out_sof, out_eol, out_valid
  );
endinterface

// File: rtl/ycbcr422_group_demux_pair_fifo.sv
// First-word-fall-through FIFO of pixel pairs; the head reads as all-zero when empty.
module ycbcr_pair_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_wr;
  logic        do_rd;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_rd = pop && !empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign do_wr = push && (!full || do_rd);
  assign dout  = empty ? T'('0) : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end
endmodule

// File: rtl/ycbcr422_group_demux.sv
// Decodes a 4:2:2 camera byte stream into aligned {Y0,Y1,Cb,Cr} pairs with
// SOF/EOL markers, buffered for a ready/valid consumer.
module ycbcr422_group_demux
  import ycbcr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           order,
  input  logic                 clear_status,
  ycbcr422_group_demux_if.slave bus,
  output logic [CNT_W-1:0]     pair_count,
  output logic                 parsing_active,
  output logic                 align_err,
  output logic                 overflow
);
  typedef struct packed {
    logic [DATA_W-1:0] y0;
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] cr;
    logic              sof;
    logic              eol;
  } pair_w_t;

  order_e           order_reg;
  order_e           eff_order;
  beat_t            beat_reg;
  beat_t            beat_next;
  beat_t            cur_beat;
  field_e           cur_field;
  logic             accept;
  logic             push;
  logic             pop;
  logic             line_close;
  logic             align_evt;
  logic             ovf_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             sof_pend_reg;
  logic             active_reg;
  logic             align_err_reg;
  logic             overflow_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DATA_W-1:0] field_byte [NUM_FIELDS];
  pair_w_t          push_pair;
  pair_w_t          head_pair;

  // The frame_start byte is beat 0 of the new frame and already uses the new order.
  always_comb begin
    eff_order  = bus.frame_start ? order_e'(order) : order_reg;
    cur_beat   = bus.frame_start ? beat_t'(0) : beat_reg;
    cur_field  = beat_field(eff_order, cur_beat);
    accept     = bus.pixel_valid && (bus.frame_start || (enable && active_reg));
    push       = accept && (cur_beat == LAST_BEAT);
    beat_next  = accept ? cur_beat + 2'd1 : cur_beat;
    line_close = bus.line_end && !bus.frame_start;
    align_evt  = line_close && (beat_next != 2'd0);
    pop        = !fifo_empty && bus.out_ready;
    ovf_evt    = push && fifo_full && !pop;

    push_pair     = '0;
    push_pair.y0  = field_byte[FLD_Y0];
    push_pair.y1  = field_byte[FLD_Y1];
    push_pair.cb  = field_byte[FLD_CB];
    push_pair.cr  = field_byte[FLD_CR];
    push_pair.sof = sof_pend_reg;
    push_pair.eol = line_close;
  end

  // Each field's staging register merged with the byte arriving this cycle.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    logic [DATA_W-1:0] stage_reg;

    assign field_byte[gi] = (accept && (cur_field == field_e'(gi))) ? bus.pixel_in : stage_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg <= '0;
      end else begin
        stage_reg <= field_byte[gi];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_reg     <= ORD_YUYV;
      beat_reg      <= '0;
      sof_pend_reg  <= 1'b0;
      count_reg     <= '0;
      active_reg    <= 1'b0;
      align_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (bus.frame_start) order_reg <= order_e'(order);
      beat_reg <= line_close ? beat_t'(0) : beat_next;

      // A dropped group still consumes the pending SOF marker.
      if (bus.frame_start)  sof_pend_reg <= 1'b1;
      else if (push)        sof_pend_reg <= 1'b0;

      if (bus.frame_start || line_close)                count_reg <= '0;
      else if (push && (count_reg != {CNT_W{1'b1}}))    count_reg <= count_reg + 1'b1;

      if (bus.frame_start) active_reg <= 1'b1;

      if (align_evt)         align_err_reg <= 1'b1;
      else if (clear_status) align_err_reg <= 1'b0;

      if (ovf_evt)           overflow_reg <= 1'b1;
      else if (clear_status) overflow_reg <= 1'b0;
    end
  end

  ycbcr_pair_fifo #(
    .T     (pair_w_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_pair),
    .pop   (pop),
    .dout  (head_pair),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_y0      = head_pair.y0;
  assign bus.out_y1      = head_pair.y1;
  assign bus.out_cb      = head_pair.cb;
  assign bus.out_cr      = head_pair.cr;
  assign bus.out_sof     = head_pair.sof;
  assign bus.out_eol     = head_pair.eol;
  assign bus.out_valid   = !fifo_empty;
  assign pair_count      = count_reg;
  assign parsing_active  = active_reg;
  assign align_err       = align_err_reg;
  assign overflow        = overflow_reg;
endmodule

// File: tb/tb_ycbcr422_group_demux.sv
// Bench for ycbcr422_group_demux: directed scenarios then random traffic, all
// compared each cycle against a byte-list/queue reference model.
module tb_ycbcr422_group_demux;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [1:0]       order = 2'd0;
  logic             clear_status = 1'b0;
  logic [CNT_W-1:0] pair_count;
  logic             parsing_active;
  logic             align_err;
  logic             overflow;

  ycbcr422_group_demux_if #(.DATA_W(DATA_W)) bus ();

  ycbcr422_group_demux #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .order          (order),
    .clear_status   (clear_status),
    .bus            (bus),
    .pair_count     (pair_count),
    .parsing_active (parsing_active),
    .align_err      (align_err),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y0;
    logic [7:0] y1;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       sof;
    logic       eol;
  } mpair_t;

  // Position of each sample within a 4-byte group, indexed by byte order.
  int y0_pos [4] = '{0, 1, 0, 1};
  int y1_pos [4] = '{2, 3, 2, 3};
  int cb_pos [4] = '{1, 0, 3, 2};
  int cr_pos [4] = '{3, 2, 1, 0};

  mpair_t     m_fifo [$];
  logic [7:0] m_group [$];
  int         m_order;
  bit         m_active, m_sof, m_align, m_ovf;
  int         m_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] t1_bytes [4] = '{8'd10, 8'd80, 8'd20, 8'd90};
  logic [7:0] t2_bytes [4] = '{8'd80, 8'd10, 8'd90, 8'd20};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_group.delete();
    m_order  = 0;
    m_active = 0;
    m_sof    = 0;
    m_align  = 0;
    m_ovf    = 0;
    m_count  = 0;
  endtask

  task automatic model_update(input bit fs, input bit le, input bit pv,
                              input logic [7:0] b, input bit rdy);
    mpair_t p;
    bit     acc;
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (clear_status) begin
      m_align = 0;
      m_ovf   = 0;
    end
    if (fs) begin
      m_group.delete();
      m_order  = int'(order);
      m_sof    = 1;
      m_count  = 0;
      m_active = 1;
    end
    acc = pv && (fs || (enable && m_active));
    if (acc) begin
      m_group.push_back(b);
      if (m_group.size() == 4) begin
        p.y0  = m_group[y0_pos[m_order]];
        p.y1  = m_group[y1_pos[m_order]];
        p.cb  = m_group[cb_pos[m_order]];
        p.cr  = m_group[cr_pos[m_order]];
        p.sof = m_sof;
        p.eol = le && !fs;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(p);
        else                       m_ovf = 1;
        if (m_count < CNT_MAX) m_count++;
        m_sof = 0;
        m_group.delete();
      end
    end
    if (le && !fs) begin
      if (m_group.size() != 0) m_align = 1;
      m_group.delete();
      m_count = 0;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0)
      chk("out_pair", 64'({bus.out_y0, bus.out_y1, bus.out_cb, bus.out_cr, bus.out_sof, bus.out_eol}),
          64'(m_fifo[0]));
    chk("pair_count", 64'(pair_count), 64'(m_count));
    chk("align_err", 64'(align_err), 64'(m_align));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("parsing_active", 64'(parsing_active), 64'(m_active));
  endtask

  task automatic cycle(input bit fs, input bit le, input bit pv,
                       input logic [7:0] b, input bit rdy);
    bus.frame_start = fs;
    bus.line_end    = le;
    bus.pixel_valid = pv;
    bus.pixel_in    = b;
    bus.out_ready   = rdy;
    @(posedge clk);
    model_update(fs, le, pv, b, rdy);
    #1;
    check_all();
    $display("cycle fs=%0b le=%0b pv=%0b byte=%0d rdy=%0b -> valid=%0b cnt=%0d aerr=%0b ovf=%0b",
             fs, le, pv, b, rdy, bus.out_valid, pair_count, align_err, overflow);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_data"}, 64'({bus.out_y0, bus.out_y1, bus.out_cb, bus.out_cr, bus.out_sof, bus.out_eol}), 64'd0);
    chk({tag, "_count"}, 64'(pair_count), 64'd0);
    chk({tag, "_flags"}, 64'({parsing_active, align_err, overflow}), 64'd0);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.line_end    = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    bus.out_ready   = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: YUYV group, pair valid the cycle after byte 3
    enable = 1'b1;
    order  = 2'd0;
    for (int i = 0; i < 4; i++) cycle(i == 0, 1'b0, 1'b1, t1_bytes[i], 1'b0);
    chk("t1_pair", 64'({bus.out_y0, bus.out_y1, bus.out_cb, bus.out_cr, bus.out_sof}),
        64'({8'd10, 8'd20, 8'd80, 8'd90, 1'b1}));
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // 2: UYVY latched at frame_start, mid-frame order change ignored
    order = 2'd1;
    cycle(1'b1, 1'b0, 1'b1, t2_bytes[0], 1'b0);
    cycle(1'b0, 1'b0, 1'b1, t2_bytes[1], 1'b0);
    order = 2'd0;
    cycle(1'b0, 1'b0, 1'b1, t2_bytes[2], 1'b0);
    cycle(1'b0, 1'b0, 1'b1, t2_bytes[3], 1'b0);
    chk("t2_pair", 64'({bus.out_y0, bus.out_y1, bus.out_cb, bus.out_cr}),
        64'({8'd10, 8'd20, 8'd80, 8'd90}));
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // 3: six-byte line ends misaligned
    for (int i = 0; i < 6; i++) cycle(i == 0, i == 5, 1'b1, 8'(i + 1), 1'b1);
    chk("t3_align", 64'(align_err), 64'd1);
    chk("t3_count", 64'(pair_count), 64'd0);
    clear_status = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    clear_status = 1'b0;
    chk("t3_cleared", 64'(align_err), 64'd0);

    // 4: five groups into a stalled four-entry FIFO
    for (int i = 0; i < 20; i++) cycle(i == 0, 1'b0, 1'b1, 8'(8'd100 + i), 1'b0);
    chk("t4_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    chk("t4_drained", 64'(bus.out_valid), 64'd0);

    // 5: line_end on the 8th byte marks eol; separate line_end shows count 2
    clear_status = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    clear_status = 1'b0;
    for (int i = 0; i < 8; i++) cycle(1'b0, i == 7, 1'b1, 8'(8'd40 + i), 1'b1);
    chk("t5_eol", 64'({bus.out_valid, bus.out_eol}), 64'd3);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 8'(8'd60 + i), 1'b1);
    chk("t5_count2", 64'(pair_count), 64'd2);
    cycle(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);

    // pair_count saturation
    for (int i = 0; i < 72; i++) cycle(i == 0, 1'b0, 1'b1, 8'($urandom), 1'b1);
    chk("sat_count", 64'(pair_count), 64'(CNT_MAX));

    // 6: async reset mid-group with FIFO occupied
    for (int i = 0; i < 6; i++) cycle(i == 0, 1'b0, 1'b1, 8'(8'd200 + i), 1'b0);
    chk("t6_occupied", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    order = 2'd3;
    for (int i = 0; i < 4; i++) cycle(i == 0, 1'b0, 1'b1, 8'(8'd30 + i), 1'b0);
    chk("t6_vyuy", 64'({bus.out_cr, bus.out_y0, bus.out_cb, bus.out_y1}),
        64'({8'd30, 8'd31, 8'd32, 8'd33}));

    // random traffic
    for (int i = 0; i < 800; i++) begin
      enable       = ($urandom_range(0, 15) != 0);
      order        = 2'($urandom_range(0, 3));
      clear_status = ($urandom_range(0, 31) == 0);
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end
    clear_status = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
